// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: price table, per-product stock, coin credit,
// online payment, inactivity refund, sold-out detection and restock.
module vending_machine_multi #(
    parameter int unsigned NUM_PRODUCTS = 8,
    parameter int unsigned SEL_W        = 3,
    parameter int unsigned VAL_W        = 8,
    parameter int unsigned STOCK_W      = 4,
    parameter int unsigned STOCK_INIT   = 10,
    parameter int unsigned TIMEOUT      = 64,
    parameter logic [NUM_PRODUCTS*VAL_W-1:0] PRICE_TABLE =
        {8'd45, 8'd40, 8'd35, 8'd30, 8'd25, 8'd20, 8'd15, 8'd10}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               initiate,
    input  logic [SEL_W-1:0]   selected_product,
    input  logic               coin_valid,
    input  logic [VAL_W-1:0]   coin_value,
    input  logic               payment_online,
    input  logic               abort,
    input  logic               restock,
    input  logic [SEL_W-1:0]   restock_product,
    input  logic [STOCK_W-1:0] restock_qty,
    output logic [2:0]         current_state,
    output logic               dispense,
    output logic [SEL_W-1:0]   dispensed_product,
    output logic               change_valid,
    output logic [VAL_W-1:0]   change_to_return,
    output logic [VAL_W-1:0]   selected_price,
    output logic [VAL_W-1:0]   credit,
    output logic               sold_out
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [VAL_W-1:0]   VAL_MAX   = '1;
    localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_DISPENSE = 3'd2,
        S_CHANGE   = 3'd3,
        S_REFUND   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [VAL_W-1:0]   price_q, price_d;
    logic [VAL_W-1:0]   credit_q, credit_d;
    logic [VAL_W-1:0]   change_q, change_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               online_q, online_d;
    logic               dispense_q, dispense_d;
    logic [SEL_W-1:0]   disp_prod_q, disp_prod_d;
    logic               change_valid_q, change_valid_d;
    logic               sold_out_q, sold_out_d;
    logic [STOCK_W-1:0] stock_q [NUM_PRODUCTS];
    logic [STOCK_W-1:0] stock_d [NUM_PRODUCTS];

    logic               sel_ok;
    logic [STOCK_W-1:0] sel_stock;
    logic [VAL_W-1:0]   sel_price;
    logic [VAL_W:0]     coin_sum;
    logic [STOCK_W:0]   stock_sum;

    // Lookup of the requested product; indices outside the table leave sel_ok low.
    always_comb begin
        sel_ok    = 1'b0;
        sel_stock = '0;
        sel_price = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (selected_product == SEL_W'(i)) begin
                sel_ok    = 1'b1;
                sel_stock = stock_q[i];
                sel_price = PRICE_TABLE[i*VAL_W +: VAL_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        price_d     = price_q;
        credit_d    = credit_q;
        change_d    = change_q;
        cnt_d       = cnt_q;
        online_d    = online_q;
        disp_prod_d = disp_prod_q;
        sold_out_d  = 1'b0;
        coin_sum    = {1'b0, credit_q} + {1'b0, coin_value};

        case (state_q)
            S_IDLE: begin
                if (initiate && !abort) begin
                    idx_d = selected_product;
                    if (!sel_ok || sel_stock == '0) begin
                        sold_out_d = 1'b1;
                    end else begin
                        state_d  = S_COLLECT;
                        price_d  = sel_price;
                        credit_d = '0;
                        cnt_d    = '0;
                        online_d = 1'b0;
                    end
                end
            end
            S_COLLECT: begin
                if (abort) begin
                    state_d  = S_REFUND;
                    change_d = credit_q;
                end else if (payment_online) begin
                    state_d  = S_DISPENSE;
                    online_d = 1'b1;
                end else if (coin_valid) begin
                    credit_d = coin_sum[VAL_W] ? VAL_MAX : coin_sum[VAL_W-1:0];
                    cnt_d    = '0;
                    if (credit_d >= price_q) state_d = S_DISPENSE;
                end else if (credit_q >= price_q) begin
                    // covers a zero price: dispense without any payment
                    state_d = S_DISPENSE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d  = S_REFUND;
                    change_d = credit_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DISPENSE: begin
                state_d  = S_CHANGE;
                change_d = online_q ? '0 : credit_q - price_q;
            end
            S_CHANGE, S_REFUND: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DISPENSE) disp_prod_d = idx_q;
        dispense_d     = (state_d == S_DISPENSE);
        change_valid_d = (state_d == S_CHANGE) || (state_d == S_REFUND);
    end

    // Stock update: dispense decrement and restock combine before saturation.
    always_comb begin
        stock_sum = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            stock_sum = {1'b0, stock_q[i]};
            if (state_q == S_DISPENSE && idx_q == SEL_W'(i))
                stock_sum = stock_sum - (STOCK_W+1)'(1);
            if (restock && restock_product == SEL_W'(i))
                stock_sum = stock_sum + {1'b0, restock_qty};
            stock_d[i] = (stock_sum > {1'b0, STOCK_MAX}) ? STOCK_MAX
                                                         : stock_sum[STOCK_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            price_q        <= '0;
            credit_q       <= '0;
            change_q       <= '0;
            cnt_q          <= '0;
            online_q       <= 1'b0;
            dispense_q     <= 1'b0;
            disp_prod_q    <= '0;
            change_valid_q <= 1'b0;
            sold_out_q     <= 1'b0;
            for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            price_q        <= price_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            cnt_q          <= cnt_d;
            online_q       <= online_d;
            dispense_q     <= dispense_d;
            disp_prod_q    <= disp_prod_d;
            change_valid_q <= change_valid_d;
            sold_out_q     <= sold_out_d;
            for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= stock_d[i];
        end
    end

    assign current_state     = state_q;
    assign dispense          = dispense_q;
    assign dispensed_product = disp_prod_q;
    assign change_valid      = change_valid_q;
    assign change_to_return  = change_q;
    assign selected_price    = price_q;
    assign credit            = credit_q;
    assign sold_out          = sold_out_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi, built with single-unit stock and a 255 top price.
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       initiate;
    logic [2:0] selected_product;
    logic       coin_valid;
    logic [7:0] coin_value;
    logic       payment_online;
    logic       abort;
    logic       restock;
    logic [2:0] restock_product;
    logic [3:0] restock_qty;
    logic [2:0] current_state;
    logic       dispense;
    logic [2:0] dispensed_product;
    logic       change_valid;
    logic [7:0] change_to_return;
    logic [7:0] selected_price;
    logic [7:0] credit;
    logic       sold_out;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vending_machine_multi #(
        .NUM_PRODUCTS(8), .SEL_W(3), .VAL_W(8), .STOCK_W(4),
        .STOCK_INIT(1), .TIMEOUT(64),
        .PRICE_TABLE({8'd255, 8'd40, 8'd35, 8'd30, 8'd25, 8'd20, 8'd15, 8'd10})
    ) dut (
        .clk(clk), .rst(rst), .initiate(initiate), .selected_product(selected_product),
        .coin_valid(coin_valid), .coin_value(coin_value), .payment_online(payment_online),
        .abort(abort), .restock(restock), .restock_product(restock_product),
        .restock_qty(restock_qty), .current_state(current_state), .dispense(dispense),
        .dispensed_product(dispensed_product), .change_valid(change_valid),
        .change_to_return(change_to_return), .selected_price(selected_price),
        .credit(credit), .sold_out(sold_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full online purchase; change is always 0 for online payment.
    task automatic buy_online(input logic [2:0] sel);
        initiate = 1'b1; selected_product = sel; payment_online = 1'b1;
        tick();
        check("buy_collect_state", current_state, 1);
        initiate = 1'b0;
        tick();
        check("buy_dispense_state", current_state, 2);
        check("buy_dispense", dispense, 1);
        check("buy_product", dispensed_product, sel);
        tick();
        check("buy_change_state", current_state, 3);
        check("buy_dispense_low", dispense, 0);
        check("buy_change_valid", change_valid, 1);
        check("buy_change_zero", change_to_return, 0);
        payment_online = 1'b0;
        tick();
        check("buy_idle_state", current_state, 0);
        check("buy_change_valid_low", change_valid, 0);
    endtask

    task automatic expect_sold_out(input logic [2:0] sel);
        initiate = 1'b1; selected_product = sel;
        tick();
        check("sold_out_pulse", sold_out, 1);
        check("sold_out_stay_idle", current_state, 0);
        initiate = 1'b0;
        tick();
        check("sold_out_low", sold_out, 0);
        check("sold_out_idle", current_state, 0);
    endtask

    initial begin
        rst = 1'b1; initiate = 1'b0; selected_product = '0; coin_valid = 1'b0;
        coin_value = '0; payment_online = 1'b0; abort = 1'b0; restock = 1'b0;
        restock_product = '0; restock_qty = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_state", current_state, 0);
        check("reset_credit", credit, 0);
        check("reset_price", selected_price, 0);
        check("reset_change", change_to_return, 0);
        check("reset_pulses", {dispense, change_valid, sold_out}, 0);

        // Online purchase of product 0 consumes its only unit.
        buy_online(3'd0);
        expect_sold_out(3'd0);

        // Coins 10+10 for price 15 -> change 5.
        initiate = 1'b1; selected_product = 3'd1;
        tick();
        initiate = 1'b0;
        check("t2_price", selected_price, 15);
        check("t2_credit0", credit, 0);
        coin_valid = 1'b1; coin_value = 8'd10;
        tick();
        check("t2_credit10", credit, 10);
        check("t2_collect", current_state, 1);
        tick();
        check("t2_credit20", credit, 20);
        check("t2_dispense_state", current_state, 2);
        check("t2_dispense", dispense, 1);
        check("t2_product", dispensed_product, 1);
        coin_valid = 1'b0;
        tick();
        check("t2_change_state", current_state, 3);
        check("t2_change_valid", change_valid, 1);
        check("t2_change", change_to_return, 5);
        tick();
        check("t2_idle", current_state, 0);
        check("t2_credit_clear", credit, 0);
        check("t2_change_hold", change_to_return, 5);

        // Abort with a same-cycle coin refunds only earlier credit.
        initiate = 1'b1; selected_product = 3'd4;
        tick();
        initiate = 1'b0;
        check("t3_price", selected_price, 30);
        coin_valid = 1'b1; coin_value = 8'd20;
        tick();
        check("t3_credit", credit, 20);
        abort = 1'b1; coin_value = 8'd5;
        tick();
        abort = 1'b0; coin_valid = 1'b0;
        check("t3_refund_state", current_state, 4);
        check("t3_refund_valid", change_valid, 1);
        check("t3_refund_amount", change_to_return, 20);
        check("t3_no_dispense", dispense, 0);
        tick();
        check("t3_idle", current_state, 0);
        check("t3_credit_clear", credit, 0);

        // Inactivity timeout; a coin in the last idle cycle restarts the count.
        initiate = 1'b1; selected_product = 3'd4;
        tick();
        initiate = 1'b0;
        coin_valid = 1'b1; coin_value = 8'd10;
        tick();
        coin_valid = 1'b0;
        check("t4_credit10", credit, 10);
        repeat (63) tick();
        check("t4_before_timeout", current_state, 1);
        coin_valid = 1'b1; coin_value = 8'd5;
        tick();
        coin_valid = 1'b0;
        check("t4_coin_restart_state", current_state, 1);
        check("t4_credit15", credit, 15);
        repeat (63) tick();
        check("t4_still_collect", current_state, 1);
        check("t4_no_early_refund", change_valid, 0);
        tick();
        check("t4_refund_state", current_state, 4);
        check("t4_refund_valid", change_valid, 1);
        check("t4_refund_amount", change_to_return, 15);
        tick();
        check("t4_idle", current_state, 0);

        // Refunds left product 4 stock intact.
        buy_online(3'd4);
        expect_sold_out(3'd4);

        // Sold out, restock, then exactly three more purchases.
        buy_online(3'd2);
        expect_sold_out(3'd2);
        restock = 1'b1; restock_product = 3'd2; restock_qty = 4'd3;
        tick();
        restock = 1'b0;
        buy_online(3'd2);
        buy_online(3'd2);
        buy_online(3'd2);
        expect_sold_out(3'd2);

        // Credit saturation and reset mid-transaction.
        initiate = 1'b1; selected_product = 3'd7;
        tick();
        initiate = 1'b0;
        check("t6_price", selected_price, 255);
        coin_valid = 1'b1; coin_value = 8'd200;
        tick();
        coin_valid = 1'b0;
        check("t6_credit200", credit, 200);
        rst = 1'b1;
        #1;
        check("t6_async_reset_state", current_state, 0);
        check("t6_async_reset_credit", credit, 0);
        check("t6_async_reset_no_change", change_valid, 0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_post_reset_no_change", change_valid, 0);
        check("t6_post_reset_change", change_to_return, 0);
        initiate = 1'b1; selected_product = 3'd7;
        tick();
        initiate = 1'b0;
        coin_valid = 1'b1; coin_value = 8'd200;
        tick();
        coin_value = 8'd100;
        tick();
        coin_valid = 1'b0;
        check("t6_credit_sat", credit, 255);
        check("t6_sat_dispense", current_state, 2);
        tick();
        check("t6_sat_change", change_to_return, 0);
        check("t6_sat_change_valid", change_valid, 1);
        tick();
        check("t6_idle", current_state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
